uarttx_frame_sender: RTL and testbench
======================================

// Module: uarttx_frame_sender
// PURPOSE
//  Serializes a wide parallel block into back-to-back UART frames on a single line; transmit counterpart of the packet receiver.
//  Captures NUM_BYTES bytes on a start request and sends each as start bit, 8 data bits LSB-first, optional parity, and stop bit.
//  Sits between the packet builder, which owns tx_data, and the board TX pin.
// PARAMETERS
//  NUM_BYTES     108  bytes per block; tx_data width is 8*NUM_BYTES
//  CLKS_PER_BIT  10   clk cycles per bit period (>=2)
// PORTS
//  clk         in   1             system clock, rising edge
//  rst         in   1             synchronous, active-high reset
//  tx_start    in   1             request; sampled only while tx_busy=0
//  tx_data     in   8*NUM_BYTES   block; byte k = tx_data[8k+7:8k], byte 0 sent first
//  serial_out  out  1             UART line, idle high, registered
//  tx_busy     out  1             high from cycle after accepted tx_start until block ends
//  tx_done     out  1             1-cycle pulse when last stop bit completes
// BEHAVIOUR
//  Clocking and reset:
//   - One clock (clk). Reset is synchronous and active-high (rst).
//   - Reset values: serial_out=1, tx_busy=0, tx_done=0, FSM=IDLE, all counters=0.
//   - rst asserted mid-block aborts on the next edge: line goes high, no tx_done pulse.
//  FSM states:
//   - IDLE: tx_start=1 -> capture tx_data into a shift register, byte_cnt=0, go to START.
//   - START -> DATA (8 bits) -> [PARITY] -> STOP. Each state/bit lasts exactly CLKS_PER_BIT cycles.
//   - STOP end: byte_cnt==NUM_BYTES-1 -> IDLE with tx_done=1; otherwise byte_cnt++, shift in next byte, go to START.
//   - No idle gap between frames.
//  Timing:
//   - serial_out=0 (start bit) on the first cycle after the accepted edge.
//   - Frame length F = 10*CLKS_PER_BIT (11* with parity).
//   - Block length = NUM_BYTES*F cycles. tx_done asserts on the cycle after the last stop-bit cycle; tx_busy=0 that same cycle.
//  Input handling:
//   - tx_start while busy is ignored, not queued.
//   - tx_data is don't-care after capture.
//   - tx_start high on the tx_done cycle is accepted: seamless next block.
//  Counters:
//   - bit timer counts 0..CLKS_PER_BIT-1 and wraps; its terminal count advances bit_idx.
//   - bit_idx is 0..7 in DATA.
//   - byte_cnt width is $clog2(NUM_BYTES); it must not wrap within a block.
// CONFIGURATION
//  `UARTTX_PARITY_EN defined:
//   - PARITY state inserted after DATA, sending even parity (^byte). Frame = 11 bit periods.
//  Not defined:
//   - 8N1 frame, 10 bit periods; PARITY state and its logic absent.
// STRUCTURE
//  Package uarttx_pkg:
//   - state_t enum {IDLE, START, DATA, PARITY, STOP}
//   - START_BIT=1'b0, STOP_BIT=1'b1, DATA_BITS=8
//  Sub-module uarttx_bit_timer:
//   - ports: clk, rst, enable, clear; output bit_strobe on terminal count
//   - instantiated once
//  Top level holds the FSM, block shift register, and byte/bit counters.
// TESTING
//  All tests use NUM_BYTES=2, CLKS_PER_BIT=10 unless stated.
//  1. tx_data=16'hA53C, pulse tx_start -> line low 10 cyc, bits 0,0,1,1,1,1,0,0 (0x3C LSB-first), stop high, then 0xA5 frame; tx_done at cycle 201.
//  2. tx_start held high across whole block -> exactly one block sent; second block starts on tx_done cycle with no gap.
//  3. tx_start pulsed at cycle 50 of a block -> ignored; total 2 frames, one tx_done.
//  4. rst at cycle 73 (mid data bit) -> serial_out=1 next edge, tx_busy=0, no tx_done; new tx_start after reset sends a clean block.
//  5. With `UARTTX_PARITY_EN: byte 0x07 -> parity bit 1, 0x03 -> 0; tx_done at cycle 221.
//  6. NUM_BYTES=108 with random 864-bit data, looped into the packet receiver -> rx_data == tx_data and data_ready fires once.

Source files
------------

// File: rtl/uarttx_pkg.sv
// Shared types and constants for the UART block transmitter.
// The optional parity bit is enabled by defining UARTTX_PARITY_EN.
package uarttx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;
  localparam int   DATA_BITS = 8;

endpackage : uarttx_pkg

// File: rtl/uarttx_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while enabled and flags the
// terminal count so the frame FSM can advance to the next bit.
module uarttx_bit_timer
  import uarttx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic clear,
  output logic bit_strobe
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q;

  // Free-running bit counter that wraps at the end of each bit period.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst || clear) begin
      cnt_q <= '0;
    end else if (enable) begin
      cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    end
  end

  assign bit_strobe = enable && (cnt_q == LAST);

endmodule : uarttx_bit_timer

// File: rtl/uarttx_frame_sender.sv
// UART block transmitter: captures NUM_BYTES bytes on tx_start and sends them
// as back-to-back frames (start, 8 data LSB-first, [even parity], stop).
// Define UARTTX_PARITY_EN to insert the even-parity bit (8E1 frames).
module uarttx_frame_sender
  import uarttx_pkg::*;
#(
  parameter int NUM_BYTES    = 108,
  parameter int CLKS_PER_BIT = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   tx_start,
  input  logic [8*NUM_BYTES-1:0] tx_data,
  output logic                   serial_out,
  output logic                   tx_busy,
  output logic                   tx_done
);

  localparam int BW = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam logic [BW-1:0] LAST_BYTE = BW'(NUM_BYTES - 1);

  state_t                 state_q, state_d;
  logic [8*NUM_BYTES-1:0] block_q, block_d;
  logic [BW-1:0]          byte_cnt_q, byte_cnt_d;
  logic [2:0]             bit_idx_q, bit_idx_d;
  logic [7:0]             byte_d;
  logic                   serial_d, busy_d, done_d;
  logic                   timer_clear, bit_strobe;

  uarttx_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk       (clk),
    .rst       (rst),
    .enable    (state_q != IDLE),
    .clear     (timer_clear),
    .bit_strobe(bit_strobe)
  );

  // State, counters and registered line outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      byte_cnt_q <= '0;
      bit_idx_q  <= '0;
      serial_out <= STOP_BIT;
      tx_busy    <= 1'b0;
      tx_done    <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      bit_idx_q  <= bit_idx_d;
      serial_out <= serial_d;
      tx_busy    <= busy_d;
      tx_done    <= done_d;
    end
  end

  // Block shift register: pure datapath, always reloaded on capture.
  always_ff @(posedge clk) begin
    // NOTE: the wide data register has no reset; its contents are never
    // observed before a capture overwrites them, so a reset would only add fanout.
    block_q <= block_d;
  end

  // Next-state, counter and line-level logic for the frame sequence.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    state_d     = state_q;
    block_d     = block_q;
    byte_cnt_d  = byte_cnt_q;
    bit_idx_d   = bit_idx_q;
    done_d      = 1'b0;
    timer_clear = 1'b0;

    case (state_q)
      IDLE: begin
        if (tx_start) begin
          block_d     = tx_data;
          byte_cnt_d  = '0;
          bit_idx_d   = '0;
          timer_clear = 1'b1;
          state_d     = START;
        end
      end
      START: begin
        if (bit_strobe) begin
          bit_idx_d = '0;
          state_d   = DATA;
        end
      end
      DATA: begin
        if (bit_strobe) begin
          if (bit_idx_q == 3'(DATA_BITS - 1)) begin
            bit_idx_d = '0;
`ifdef UARTTX_PARITY_EN
            state_d   = PARITY;
`else
            state_d   = STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
`ifdef UARTTX_PARITY_EN
      PARITY: begin
        if (bit_strobe) state_d = STOP;
      end
`endif
      STOP: begin
        if (bit_strobe) begin
          if (byte_cnt_q == LAST_BYTE) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            byte_cnt_d = byte_cnt_q + BW'(1);
            block_d    = block_q >> 8;
            state_d    = START;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Line level for the coming cycle, so serial_out is a plain register.
    byte_d   = block_d[7:0];
    busy_d   = (state_d != IDLE);
    serial_d = STOP_BIT;
    case (state_d)
      START:   serial_d = START_BIT;
      DATA:    serial_d = byte_d[bit_idx_d];
`ifdef UARTTX_PARITY_EN
      PARITY:  serial_d = ^byte_d;
`endif
      default: serial_d = STOP_BIT;
    endcase
  end

endmodule : uarttx_frame_sender

// File: tb/tb_uarttx_frame_sender.sv
// Self-checking bench for uarttx_frame_sender (NUM_BYTES=2, CLKS_PER_BIT=10).
// Honours UARTTX_PARITY_EN to expect 11-bit frames.
module tb_uarttx_frame_sender;

  localparam int NB   = 2;
  localparam int CPB  = 10;
`ifdef UARTTX_PARITY_EN
  localparam int BITS = 11;
`else
  localparam int BITS = 10;
`endif
  localparam int F    = BITS * CPB;
  localparam int NF   = NB * F;

  logic            clk = 1'b0;
  logic            rst;
  logic            tx_start;
  logic [8*NB-1:0] tx_data;
  logic            serial_out, tx_busy, tx_done;

  int total = 0;
  int bad   = 0;

  uarttx_frame_sender #(
    .NUM_BYTES   (NB),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .tx_start  (tx_start),
    .tx_data   (tx_data),
    .serial_out(serial_out),
    .tx_busy   (tx_busy),
    .tx_done   (tx_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference line level for cycle t (1-based) of a block carrying data.
  function automatic logic exp_line(input logic [8*NB-1:0] data, input int t);
    int         f   = t - 1;
    int         frm = f / F;
    int         pos = (f % F) / CPB;
    logic [7:0] b   = data[frm*8 +: 8];
    if (pos == 0) return 1'b0;
    if (pos <= 8) return b[pos-1];
    if (pos == 9 && BITS == 11) return ^b;
    return 1'b1;
  endfunction

  // Runs one block whose accept edge is the next posedge. tx_start/tx_data
  // must already be set up. hold keeps tx_start high (next_data is presented
  // for the seamless follow-on); pulse_at raises tx_start for one cycle.
  task automatic run_block(input logic [8*NB-1:0] data, input bit hold,
                           input int pulse_at, input logic [8*NB-1:0] next_data);
    @(posedge clk);
    for (int t = 1; t <= NF + 1; t++) begin
      @(negedge clk);
      if (t == 1) begin
        tx_data  = 16'($urandom);
        tx_start = hold;
      end
      if (!hold && pulse_at > 0) tx_start = (t == pulse_at);
      if (t <= NF) begin
        check($sformatf("line[%0d]", t), serial_out, exp_line(data, t));
        check($sformatf("busy[%0d]", t), tx_busy, 1'b1);
        check($sformatf("done[%0d]", t), tx_done, 1'b0);
      end else begin
        check("line_end", serial_out, 1'b1);
        check("busy_end", tx_busy, 1'b0);
        check("done_end", tx_done, 1'b1);
        if (hold) tx_data = next_data;
      end
    end
  endtask

  task automatic check_idle(input string tag, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      check({tag, "_line"}, serial_out, 1'b1);
      check({tag, "_busy"}, tx_busy, 1'b0);
      check({tag, "_done"}, tx_done, 1'b0);
    end
  endtask

  initial begin
    logic [8*NB-1:0] d, d2;

    rst = 1'b1; tx_start = 1'b0; tx_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_line", serial_out, 1'b1);
    check("rst_busy", tx_busy, 1'b0);
    check("rst_done", tx_done, 1'b0);
    rst = 1'b0;
    check_idle("idle0", 3);

    // Directed block: 0x3C then 0xA5, tx_done on cycle NF+1.
    d = 16'hA53C;
    tx_data = d; tx_start = 1'b1;
    run_block(d, 1'b0, 0, '0);
    check_idle("idle1", 5);

    // Random blocks.
    for (int k = 0; k < 3; k++) begin
      d = 16'($urandom);
      tx_data = d; tx_start = 1'b1;
      run_block(d, 1'b0, 0, '0);
      check_idle("idle_r", 2);
    end

    // Boundary bytes with parity-sensitive values.
    d = 16'h0307;
    tx_data = d; tx_start = 1'b1;
    run_block(d, 1'b0, 0, '0);
    check_idle("idle_p", 2);

    // tx_start held for the whole block: exactly one block, then seamless next.
    d  = 16'($urandom);
    d2 = 16'($urandom);
    tx_data = d; tx_start = 1'b1;
    run_block(d, 1'b1, 0, d2);
    tx_start = 1'b1;
    tx_data  = d2;
    run_block(d2, 1'b0, 0, '0);
    check_idle("idle_h", 2 * F);

    // tx_start pulsed mid-block is ignored, not queued.
    d = 16'($urandom);
    tx_data = d; tx_start = 1'b1;
    run_block(d, 1'b0, 50, '0);
    check_idle("idle_ign", 2 * F);

    // Reset at cycle 73 aborts the block without a tx_done pulse.
    d = 16'($urandom);
    tx_data = d; tx_start = 1'b1;
    @(posedge clk);
    for (int t = 1; t <= 73; t++) begin
      @(negedge clk);
      if (t == 1) tx_start = 1'b0;
      check($sformatf("abort_line[%0d]", t), serial_out, exp_line(d, t));
    end
    rst = 1'b1;
    @(negedge clk);
    check("abort_line", serial_out, 1'b1);
    check("abort_busy", tx_busy, 1'b0);
    check("abort_done", tx_done, 1'b0);
    rst = 1'b0;
    check_idle("idle_abort", F);

    // Clean block after the abort.
    d = 16'($urandom);
    tx_data = d; tx_start = 1'b1;
    run_block(d, 1'b0, 0, '0);
    check_idle("idle_end", 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "timeout");
  end

endmodule : tb_uarttx_frame_sender
